// File: rtl/free_list_pkg.sv
// Shared constants and width helpers for the rename-stage physical register free list.
package free_list_pkg;

    localparam int ZERO_REG = 0;

    function automatic int pr_w(input int preg_num);
        return $clog2(preg_num);
    endfunction

    function automatic int ckpt_w(input int ckpt_num);
        return (ckpt_num > 1) ? $clog2(ckpt_num) : 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Wrap-bit head pointer as held in a checkpoint slot, sized for the default 64/32 build.
    typedef logic [ptr_w(64 - 32)-1:0] ckpt_ptr_t;

endpackage

// File: rtl/lane_prefix_cnt.sv
// Per-lane running popcount of a lane-enable vector.
// incl[WAYS-1] doubles as the total count.
module lane_prefix_cnt #(
    parameter int WAYS  = 2,
    parameter int CNT_W = $clog2(WAYS + 1)
) (
    input  logic [WAYS-1:0]            vec,
    output logic [WAYS-1:0][CNT_W-1:0] excl,
    output logic [WAYS-1:0][CNT_W-1:0] incl
);

    always_comb begin
        logic [CNT_W-1:0] run;
        run  = '0;
        excl = '0;
        incl = '0;
        for (int i = 0; i < WAYS; i++) begin
            excl[i] = run;
            run     = run + CNT_W'(vec[i]);
            incl[i] = run;
        end
    end

endmodule

// File: rtl/free_list_ckpt.sv
// Circular free list of physical register tags with WAYS-wide allocate/reclaim
// and per-branch head checkpoints restored in one cycle on mispredict.
module free_list_ckpt
    import free_list_pkg::*;
#(
    parameter  int PREG_NUM = 64,
    parameter  int AREG_NUM = 32,
    parameter  int WAYS     = 2,
    parameter  int CKPT_NUM = 4,
    localparam int PR_W     = pr_w(PREG_NUM),
    localparam int CKPT_W   = ckpt_w(CKPT_NUM),
    localparam int FL_DEPTH = PREG_NUM - AREG_NUM,
    localparam int IDX_W    = $clog2(FL_DEPTH),
    localparam int PTR_W    = ptr_w(FL_DEPTH),
    localparam int CNT_W    = $clog2(WAYS + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WAYS-1:0]             disp_en,
    input  logic [WAYS-1:0]             disp_br,
    input  logic [WAYS-1:0][CKPT_W-1:0] disp_br_tag,
    input  logic [WAYS-1:0]             retire_en,
    input  logic [WAYS-1:0][PR_W-1:0]   retire_told,
    input  logic                        br_mispredict,
    input  logic [CKPT_W-1:0]           br_mis_tag,
    output logic [WAYS-1:0][PR_W-1:0]   fl_T,
    output logic [WAYS-1:0]             fl_grant,
    output logic [PR_W:0]               fl_free_cnt,
    output logic [WAYS-1:0]             fl_stall
);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [PR_W-1:0] entry [FL_DEPTH];
    ptr_t            ckpt  [CKPT_NUM];
    ptr_t            head, tail, cnt, alloc_n;

    logic [WAYS-1:0][CNT_W-1:0] d_excl, d_incl, r_excl, r_incl;

    function automatic logic [IDX_W-1:0] idx(input ptr_t p);
        return p[IDX_W-1:0];
    endfunction

    // Grants are the first min(n, free) enabled lanes, so their count is a clamp.
    function automatic ptr_t sat(input logic [CNT_W-1:0] n, input ptr_t lim);
        return (int'(n) < int'(lim)) ? ptr_t'(n) : lim;
    endfunction

    lane_prefix_cnt #(.WAYS(WAYS), .CNT_W(CNT_W)) u_disp_cnt (
        .vec  (disp_en),
        .excl (d_excl),
        .incl (d_incl)
    );

    lane_prefix_cnt #(.WAYS(WAYS), .CNT_W(CNT_W)) u_ret_cnt (
        .vec  (retire_en),
        .excl (r_excl),
        .incl (r_incl)
    );

    assign cnt         = tail - head;
    assign fl_free_cnt = (PR_W + 1)'(cnt);

    always_comb begin
        fl_grant = '0;
        fl_T     = '0;
        fl_stall = '0;
        alloc_n  = br_mispredict ? '0 : sat(d_incl[WAYS-1], cnt);
        for (int i = 0; i < WAYS; i++) begin
            fl_stall[i] = int'(cnt) < (i + 1);
            fl_grant[i] = disp_en[i] && !br_mispredict && (int'(d_excl[i]) < int'(cnt));
            fl_T[i]     = fl_grant[i] ? entry[idx(head + ptr_t'(d_excl[i]))] : PR_W'(ZERO_REG);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head <= '0;
            tail <= ptr_t'(FL_DEPTH);
            for (int i = 0; i < FL_DEPTH; i++) entry[i] <= PR_W'(AREG_NUM + i);
            for (int c = 0; c < CKPT_NUM; c++) ckpt[c] <= '0;
        end else begin
            for (int i = 0; i < WAYS; i++)
                if (retire_en[i]) entry[idx(tail + ptr_t'(r_excl[i]))] <= retire_told[i];
            tail <= tail + ptr_t'(r_incl[WAYS-1]);
            if (br_mispredict) begin
                head <= ckpt[br_mis_tag];
            end else begin
                head <= head + alloc_n;
                // ascending lane order lets the highest lane win a shared tag
                for (int i = 0; i < WAYS; i++)
                    if (disp_br[i]) ckpt[disp_br_tag[i]] <= head + sat(d_incl[i], cnt);
            end
        end
    end

    // Net occupancy after this cycle's grants and reclaims must fit the list.
    always_ff @(posedge clock)
        if (reset) assert (int'(cnt) - int'(alloc_n) + int'(r_incl[WAYS-1]) <= FL_DEPTH);

endmodule
